daug_wcs_ctrl: RTL and testbench

- Clocked, parametrised successor to the daughterboard CAS/ROM-select PAL.
- Arbitrates each 68000 access between boot ROM and writable-control-store (WCS) RAM across NBANK banks and LANES byte lanes.
- Has per-bank write-protect latches, a programmable CAS length, an acknowledge handshake and bus-error generation.
- Sits between the Agnus/Gary-side decode (RE) and the ROM/RAM chip enables. All ports are active-high; pad inversion to the _XXX pins is done outside this block.

---
 rtl/daug_pkg.sv | 37 +++
 rtl/daug_wprot_bank.sv | 46 ++++
 rtl/daug_wcs_ctrl.sv | 168 ++++++++++++++++
 tb/tb_daug_wcs_ctrl.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/daug_pkg.sv
// Shared types for the daughterboard WCS controller: FSM states, access kinds
// and the default CAS length.
package daug_pkg;

  localparam int CAS_CYCLES_DEF = 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOCK,
    S_ROMRD,
    S_RD,
    S_WR,
    S_ERR,
    S_DONE
  } state_e;

  typedef enum logic [2:0] {
    K_NONE,
    K_LOCK,
    K_ROM,
    K_RD,
    K_WR,
    K_ERR
  } kind_e;

  function automatic state_e kind_to_state(kind_e k);
    case (k)
      K_LOCK:  return S_LOCK;
      K_ROM:   return S_ROMRD;
      K_RD:    return S_RD;
      K_WR:    return S_WR;
      K_ERR:   return S_ERR;
      default: return S_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/daug_wprot_bank.sv
// Per-bank write-protect latches: set-only from a LOCK access, cleared only
// by reset, with an indexed lookup that also folds in software-ROM mode.
module daug_wprot_bank
  import daug_pkg::*;
#(
  parameter int NBANK = 2,
  parameter int IDX_W = 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_set,
  input  logic [IDX_W-1:0] i_set_idx,
  input  logic [IDX_W-1:0] i_rd_idx,
  input  logic             i_srom,
  output logic [NBANK-1:0] o_lock,
  output logic             o_locked,
  output logic             o_prot
);

  logic [NBANK-1:0] r_lock;
  logic             w_locked;

  // NOTE: sequential state is written with non-blocking assignments only.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_lock <= '0;
    end else if (i_set) begin
      for (int i = 0; i < NBANK; i++) begin
        if (i_set_idx == IDX_W'(i)) r_lock[i] <= 1'b1;
      end
    end
  end

  // Indices past NBANK read as unlocked; the top handles them explicitly.
  always_comb begin
    w_locked = 1'b0;
    for (int i = 0; i < NBANK; i++) begin
      if (i_rd_idx == IDX_W'(i)) w_locked = r_lock[i];
    end
  end

  assign o_lock   = r_lock;
  assign o_locked = w_locked;
  assign o_prot   = w_locked | i_srom;

endmodule

// File: rtl/daug_wcs_ctrl.sv
// 68000 access arbiter between boot ROM and WCS RAM: decodes the access kind
// at start, times CAS, drives ACK/BERR, and holds strobes until the bus lets go.
module daug_wcs_ctrl
  import daug_pkg::*;
#(
  parameter int  NBANK      = 2,
  parameter int  LANES      = 2,
  parameter int  CAS_CYCLES = CAS_CYCLES_DEF,
  localparam int BSEL_W     = (NBANK > 1) ? $clog2(NBANK) : 1
) (
  input  logic              C1,
  input  logic              RES,
  input  logic              RE,
  input  logic              PRW,
  input  logic [LANES-1:0]  DS,
  input  logic              CTRL,
  input  logic [BSEL_W-1:0] BSEL,
  input  logic              SROM,
  output logic [NBANK-1:0]  ROMEN,
  output logic [LANES-1:0]  CEN,
  output logic              CDR,
  output logic              CDW,
  output logic              RRW,
  output logic              ACK,
  output logic              BERR,
  output logic [NBANK-1:0]  WPRO
);

  localparam int CNT_W = $clog2(CAS_CYCLES + 1);

  state_e              r_state;
  kind_e               r_kind;
  logic [LANES-1:0]    r_ds;
  logic [BSEL_W-1:0]   r_bsel;
  logic [CNT_W-1:0]    r_cnt;
  logic [NBANK-1:0]    r_romen;
  logic [LANES-1:0]    r_cen;
  logic                r_cdr, r_cdw, r_rrw, r_ack, r_berr;

  state_e              w_state_nxt;
  kind_e               w_kind;
  logic [CNT_W-1:0]    w_cnt_nxt;
  logic                w_start, w_oor, w_locked, w_prot, w_set;
  logic                w_strobe, w_ack, w_berr;
  logic [NBANK-1:0]    w_romen;

  assign w_start = RE && (DS != '0);
  assign w_oor   = int'(BSEL) >= NBANK;
  assign w_set   = (r_state == S_IDLE) && w_start && (w_kind == K_LOCK);

  daug_wprot_bank #(
    .NBANK (NBANK),
    .IDX_W (BSEL_W)
  ) u_wprot (
    .i_clk     (C1),
    .i_rst     (RES),
    .i_set     (w_set),
    .i_set_idx (BSEL),
    .i_rd_idx  (BSEL),
    .i_srom    (SROM),
    .o_lock    (WPRO),
    .o_locked  (w_locked),
    .o_prot    (w_prot)
  );

  // Out-of-range banks behave as protected with no lock latch to set.
  always_comb begin
    w_kind = K_RD;
    if (CTRL && PRW)  w_kind = w_oor ? K_ERR : K_LOCK;
    else if (CTRL)    w_kind = (w_oor || w_prot) ? K_RD : K_ROM;
    else if (PRW)     w_kind = (w_oor || w_locked) ? K_ERR : K_WR;
  end

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_strobe    = 1'b0;
    w_ack       = 1'b0;
    w_berr      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_start) begin
          w_state_nxt = kind_to_state(w_kind);
          w_cnt_nxt   = CNT_W'(CAS_CYCLES);
        end
      end
      S_LOCK: begin
        if (RE) begin
          w_ack       = 1'b1;
          w_state_nxt = S_DONE;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_ROMRD, S_RD, S_WR: begin
        if (RE) begin
          w_strobe = 1'b1;
          if (r_cnt != '0) w_cnt_nxt = r_cnt - CNT_W'(1);
          if (r_cnt <= CNT_W'(1)) w_state_nxt = S_DONE;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_ERR: begin
        if (RE) w_berr = 1'b1;
        else    w_state_nxt = S_IDLE;
      end
      S_DONE: begin
        if (RE && (DS != '0)) begin
          w_ack    = 1'b1;
          w_strobe = 1'b1;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_romen = '0;
    for (int i = 0; i < NBANK; i++) begin
      w_romen[i] = w_strobe && (r_kind == K_ROM) && (r_bsel == BSEL_W'(i));
    end
  end

  always_ff @(posedge C1 or posedge RES) begin
    if (RES) begin
      r_state <= S_IDLE;
      r_kind  <= K_NONE;
      r_ds    <= '0;
      r_bsel  <= '0;
      r_cnt   <= '0;
      r_romen <= '0;
      r_cen   <= '0;
      r_cdr   <= 1'b0;
      r_cdw   <= 1'b0;
      r_rrw   <= 1'b0;
      r_ack   <= 1'b0;
      r_berr  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (r_state == S_IDLE && w_start) begin
        r_kind <= w_kind;
        r_ds   <= DS;
        r_bsel <= BSEL;
      end
      r_romen <= w_romen;
      r_cen   <= (w_strobe && (r_kind == K_RD || r_kind == K_WR)) ? r_ds : '0;
      r_cdr   <= w_strobe && (r_kind == K_RD);
      r_cdw   <= w_strobe && (r_kind == K_WR);
      r_rrw   <= w_strobe && (r_kind == K_WR);
      r_ack   <= w_ack;
      r_berr  <= w_berr;
    end
  end

  assign ROMEN = r_romen;
  assign CEN   = r_cen;
  assign CDR   = r_cdr;
  assign CDW   = r_cdw;
  assign RRW   = r_rrw;
  assign ACK   = r_ack;
  assign BERR  = r_berr;

endmodule

// File: tb/tb_daug_wcs_ctrl.sv
// Bench for daug_wcs_ctrl: three parameterisations share one stimulus stream and
// are compared cycle by cycle against a per-access trace model.
module tb_daug_wcs_ctrl;

  typedef enum {M_LOCK, M_ROM, M_RD, M_WR, M_ERR} mkind_e;

  typedef struct packed {
    logic [3:0] romen;
    logic [3:0] cen;
    logic       cdr;
    logic       cdw;
    logic       rrw;
    logic       ack;
    logic       berr;
    logic [3:0] wpro;
  } obs_t;

  logic       C1 = 1'b0;
  logic       RES, RE, PRW, CTRL, SROM;
  logic [3:0] DS;
  logic [1:0] BSEL;

  logic [1:0] a_romen, a_cen, a_wpro;
  logic       a_cdr, a_cdw, a_rrw, a_ack, a_berr;
  logic [2:0] b_romen, b_wpro;
  logic [3:0] b_cen;
  logic       b_cdr, b_cdw, b_rrw, b_ack, b_berr;
  logic       c_romen, c_cen, c_wpro;
  logic       c_cdr, c_cdw, c_rrw, c_ack, c_berr;

  int tests = 0;
  int fails = 0;

  int nb[3] = '{2, 3, 1};
  int cs[3] = '{2, 5, 1};
  logic [3:0] m_wpro [3];

  always #5 C1 = ~C1;

  daug_wcs_ctrl #(.NBANK(2), .LANES(2), .CAS_CYCLES(2)) dut_a (
    .C1(C1), .RES(RES), .RE(RE), .PRW(PRW), .DS(DS[1:0]), .CTRL(CTRL),
    .BSEL(BSEL[0]), .SROM(SROM), .ROMEN(a_romen), .CEN(a_cen), .CDR(a_cdr),
    .CDW(a_cdw), .RRW(a_rrw), .ACK(a_ack), .BERR(a_berr), .WPRO(a_wpro)
  );

  daug_wcs_ctrl #(.NBANK(3), .LANES(4), .CAS_CYCLES(5)) dut_b (
    .C1(C1), .RES(RES), .RE(RE), .PRW(PRW), .DS(DS), .CTRL(CTRL),
    .BSEL(BSEL), .SROM(SROM), .ROMEN(b_romen), .CEN(b_cen), .CDR(b_cdr),
    .CDW(b_cdw), .RRW(b_rrw), .ACK(b_ack), .BERR(b_berr), .WPRO(b_wpro)
  );

  daug_wcs_ctrl #(.NBANK(1), .LANES(1), .CAS_CYCLES(1)) dut_c (
    .C1(C1), .RES(RES), .RE(RE), .PRW(PRW), .DS(|DS), .CTRL(CTRL),
    .BSEL(BSEL[0]), .SROM(SROM), .ROMEN(c_romen), .CEN(c_cen), .CDR(c_cdr),
    .CDW(c_cdw), .RRW(c_rrw), .ACK(c_ack), .BERR(c_berr), .WPRO(c_wpro)
  );

  function automatic obs_t get_obs(int i);
    obs_t o;
    case (i)
      0:       o = {{2'b0, a_romen}, {2'b0, a_cen}, a_cdr, a_cdw, a_rrw, a_ack, a_berr, {2'b0, a_wpro}};
      1:       o = {{1'b0, b_romen}, b_cen, b_cdr, b_cdw, b_rrw, b_ack, b_berr, {1'b0, b_wpro}};
      default: o = {{3'b0, c_romen}, {3'b0, c_cen}, c_cdr, c_cdw, c_rrw, c_ack, c_berr, {3'b0, c_wpro}};
    endcase
    return o;
  endfunction

  // Bank index and data strobes as each instance sees the shared stimulus.
  function automatic int bank_of(int i, logic [1:0] bsel);
    return (i == 1) ? int'(bsel) : int'(bsel[0]);
  endfunction

  function automatic logic [3:0] ds_of(int i, logic [3:0] ds);
    case (i)
      0:       return {2'b0, ds[1:0]};
      1:       return ds;
      default: return {3'b0, |ds};
    endcase
  endfunction

  function automatic mkind_e classify(int i, logic ctrl, logic prw, int b, logic srom);
    bit oor = (b >= nb[i]);
    bit lk  = !oor && m_wpro[i][b];
    if (ctrl && prw) return oor ? M_ERR : M_LOCK;
    if (ctrl)        return (oor || lk || srom) ? M_RD : M_ROM;
    if (prw)         return (oor || lk) ? M_ERR : M_WR;
    return M_RD;
  endfunction

  // Expected outputs t cycles after the start edge when RE stays high for h more edges.
  function automatic obs_t expect_out(int i, mkind_e k, int t, int h, logic [3:0] ds, int b);
    obs_t       e   = '0;
    logic [3:0] one = 4'd1;
    e.wpro = m_wpro[i];
    if (t >= 1 && t <= h) begin
      case (k)
        M_LOCK: e.ack  = 1'b1;
        M_ERR:  e.berr = 1'b1;
        default: begin
          e.ack = (t >= cs[i] + 1);
          if (k == M_ROM) begin
            e.romen = one << b;
          end else begin
            e.cen = ds;
            e.cdr = (k == M_RD);
            e.cdw = (k == M_WR);
            e.rrw = (k == M_WR);
          end
        end
      endcase
    end
    return e;
  endfunction

  task automatic check(input obs_t got, input obs_t exp, input string tag, input int i, input int t);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s inst=%0d t=%0d observed=%h expected=%h", tag, i, t, got, exp);
    end
    tests++;
    assert (($countones({got.romen, got.cdr, got.cdw}) <= 1) && !(got.ack && got.berr)) else begin
      fails++;
      $error("FAIL %s_exclusive inst=%0d t=%0d observed=%h expected=at most one of romen/cdr/cdw, not ack+berr",
             tag, i, t, got);
    end
  endtask

  task automatic check_all_zero(input string tag);
    for (int i = 0; i < 3; i++) begin
      m_wpro[i] = '0;
      check(get_obs(i), obs_t'(0), tag, i, 0);
    end
  endtask

  function automatic logic [3:0] rand_ds();
    logic [3:0] d = 4'($urandom);
    if (d[1:0] == 2'b00) d[0] = 1'b1;
    return d;
  endfunction

  // Entered and left at a negedge; rst_at >= 0 pulses RES mid-access at that cycle.
  task automatic run_access(input logic ctrl, input logic prw, input logic [1:0] bsel,
                            input logic [3:0] ds, input logic srom, input int h, input int rst_at);
    mkind_e k[3];
    int     bi[3];
    CTRL = ctrl; PRW = prw; BSEL = bsel; DS = ds; SROM = srom; RE = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bi[i] = bank_of(i, bsel);
      k[i]  = classify(i, ctrl, prw, bi[i], srom);
    end
    @(posedge C1);
    for (int i = 0; i < 3; i++) begin
      if (k[i] == M_LOCK) m_wpro[i][bi[i]] = 1'b1;
    end
    for (int t = 0; t <= h + 1; t++) begin
      if (t > 0) @(posedge C1);
      @(negedge C1);
      for (int i = 0; i < 3; i++)
        check(get_obs(i), expect_out(i, k[i], t, h, ds_of(i, ds), bi[i]), "access", i, t);
      CTRL = 1'($urandom); PRW = 1'($urandom); BSEL = 2'($urandom); DS = rand_ds();
      if (t == rst_at) begin
        #2 RES = 1'b1;
        RE = 1'b0;
        #1 check_all_zero("async_reset");
        @(negedge C1);
        RES = 1'b0;
        return;
      end
      if (t == h) RE = 1'b0;
    end
  endtask

  task automatic idle_cycle(input logic re);
    RE = re;
    DS = 4'b0000;
    @(posedge C1);
    @(negedge C1);
    for (int i = 0; i < 3; i++)
      check(get_obs(i), expect_out(i, M_RD, 0, 0, 4'b0, 0), "no_start", i, 0);
    RE = 1'b0;
  endtask

  initial begin
    RES = 1'b1; RE = 1'b0; PRW = 1'b0; CTRL = 1'b0; DS = '0; BSEL = '0; SROM = 1'b0;
    for (int i = 0; i < 3; i++) m_wpro[i] = '0;
    repeat (2) @(negedge C1);
    check_all_zero("reset");
    RES = 1'b0;
    @(negedge C1);

    run_access(1'b1, 1'b0, 2'd0, 4'b0011, 1'b0, 3, -1);  // ROM read, bank 0
    run_access(1'b0, 1'b1, 2'd1, 4'b0010, 1'b0, 3, -1);  // RAM write, bank 1, upper lane
    run_access(1'b1, 1'b1, 2'd1, 4'b0011, 1'b0, 2, -1);  // lock bank 1
    run_access(1'b1, 1'b1, 2'd1, 4'b0011, 1'b0, 1, -1);  // relock is a no-op that ACKs
    run_access(0, 1'b1, 2'd1, 4'b0011, 1'b0, 4, -1);     // write to locked bank
    run_access(1'b1, 1'b0, 2'd1, 4'b0111, 1'b0, 3, -1);  // shadowed ROM read
    run_access(1'b1, 1'b0, 2'd0, 4'b0011, 1'b1, 3, -1);  // SROM forces RAM read
    run_access(1'b0, 1'b1, 2'd0, 4'b0001, 1'b1, 3, -1);  // SROM does not block writes
    run_access(1'b0, 1'b1, 2'd0, 4'b0011, 1'b0, 6, 1);   // reset during CAS
    run_access(1'b0, 1'b1, 2'd0, 4'b1001, 1'b0, 7, -1);  // normal after reset
    run_access(1'b0, 1'b0, 2'd0, 4'b0011, 1'b0, 1, -1);  // early RE drop
    run_access(1'b1, 1'b1, 2'd3, 4'b0011, 1'b0, 2, -1);  // out-of-range bank cases
    run_access(1'b0, 1'b1, 2'd3, 4'b0011, 1'b0, 2, -1);
    run_access(1'b1, 1'b0, 2'd3, 4'b0010, 1'b0, 7, -1);
    run_access(1'b0, 1'b0, 2'd3, 4'b0001, 1'b0, 7, -1);
    idle_cycle(1'b1);

    repeat (300) begin
      if ($urandom_range(15) == 0) begin
        RES = 1'b1;
        @(negedge C1);
        RES = 1'b0;
        check_all_zero("reset_pulse");
      end
      run_access(1'($urandom), 1'($urandom), 2'($urandom), rand_ds(), 1'($urandom_range(3) == 0),
                 int'($urandom_range(8)), ($urandom_range(9) == 0) ? int'($urandom_range(5)) : -1);
      if ($urandom_range(3) == 0) idle_cycle(1'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
